// File: rtl/acia_pkg.sv
// acia_pkg: shared FSM states and ACIA register constants
package acia_pkg;
  typedef enum logic [2:0] {INIT_MR, INIT_CFG, IDLE, POLL, CHECK, SEND} state_t;
  localparam logic [7:0] ACIA_MRST = 8'h03;
  localparam int STAT_TXE_BIT = 1;
  localparam int STAT_RXF_BIT = 0;
endpackage

// File: rtl/acia_fifo.sv
// acia_fifo: synchronous byte FIFO with wrap-bit pointers
module acia_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + (AW+1)'(1);
      if (pop && !empty) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/acia_tx_sched.sv
// acia_tx_sched: two-requester round-robin byte scheduler feeding an ACIA transmitter
module acia_tx_sched import acia_pkg::*; #(
  parameter int         DEPTH    = 16,
  parameter logic [7:0] CFG_WORD = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req0_dat,
  input  logic       req0_vld,
  output logic       req0_rdy,
  input  logic [7:0] req1_dat,
  input  logic       req1_vld,
  output logic       req1_rdy,
  output logic       acia_cs,
  output logic       acia_we,
  output logic       acia_rs,
  output logic [7:0] acia_din,
  input  logic [7:0] acia_dout,
  output logic       init_done,
  output logic       busy
);
  state_t state, state_nx;
  logic grant, grant_nx, ptr;
  logic cs, we, rs, pop0, pop1;
  logic [7:0] din, head0, head1;
  logic full0, full1, empty0, empty1;
  logic unused_dout;
  assign unused_dout = ^acia_dout;
  assign req0_rdy = init_done & ~full0;
  assign req1_rdy = init_done & ~full1;
  acia_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst_n(rst_n), .push(req0_vld & req0_rdy), .din(req0_dat), .pop(pop0),
    .dout(head0), .full(full0), .empty(empty0)
  );
  acia_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .push(req1_vld & req1_rdy), .din(req1_dat), .pop(pop1),
    .dout(head1), .full(full1), .empty(empty1)
  );
  always_comb begin
    state_nx = state;
    cs = 1'b0;
    we = 1'b0;
    rs = 1'b0;
    din = 8'h00;
    pop0 = 1'b0;
    pop1 = 1'b0;
    grant_nx = empty0 ? 1'b1 : (empty1 ? 1'b0 : ptr);
    case (state)
      INIT_MR: begin
        {cs, we} = 2'b11;
        din = ACIA_MRST;
        state_nx = INIT_CFG;
      end
      INIT_CFG: begin
        {cs, we} = 2'b11;
        din = CFG_WORD;
        state_nx = IDLE;
      end
      IDLE: state_nx = (empty0 && empty1) ? IDLE : POLL;
      POLL: begin
        cs = 1'b1;
        state_nx = CHECK;
      end
      CHECK: state_nx = acia_dout[STAT_TXE_BIT] ? SEND : POLL;
      SEND: begin
        {cs, we, rs} = 3'b111;
        din = grant ? head1 : head0;
        pop0 = ~grant;
        pop1 = grant;
        state_nx = IDLE;
      end
      default: state_nx = INIT_MR;
    endcase
  end
  // Bus strobes are gated by rst_n so they drop the instant reset asserts.
  assign acia_cs = rst_n & cs;
  assign acia_we = rst_n & we;
  assign acia_rs = rst_n & rs;
  assign acia_din = {8{rst_n}} & din;
  assign busy = rst_n & (~empty0 | ~empty1 | (state != IDLE));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT_MR;
      grant <= 1'b0;
      ptr <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) grant <= grant_nx;
      if (state == SEND) ptr <= ~grant;
      if (state == INIT_CFG) init_done <= 1'b1;
    end
endmodule

// File: tb/tb_acia_tx_sched.sv
// tb_acia_tx_sched: directed bench with a behavioural ACIA status/data model
module tb_acia_tx_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] req0_dat = 8'h00, req1_dat = 8'h00;
  logic req0_vld = 1'b0, req1_vld = 1'b0;
  logic req0_rdy, req1_rdy, acia_cs, acia_we, acia_rs, init_done, busy;
  logic [7:0] acia_din;
  logic [7:0] acia_dout = 8'h00;
  int total = 0, bad = 0;
  logic [7:0] stat = 8'h02;
  int zp = 0, rd_base = 0;
  int n_rd = 0, n_ctl = 0, bad_tx = 0;
  logic last_txe = 1'b0;
  logic [7:0] dlog[$];

  acia_tx_sched #(.DEPTH(16), .CFG_WORD(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_dat(req0_dat), .req0_vld(req0_vld), .req0_rdy(req0_rdy),
    .req1_dat(req1_dat), .req1_vld(req1_vld), .req1_rdy(req1_rdy),
    .acia_cs(acia_cs), .acia_we(acia_we), .acia_rs(acia_rs),
    .acia_din(acia_din), .acia_dout(acia_dout),
    .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // ACIA: status returns 0 for the first zp reads after rd_base, then stat
  always @(posedge clk) begin
    if (acia_cs && !acia_we) begin
      acia_dout <= (n_rd - rd_base < zp) ? 8'h00 : stat;
      last_txe <= (n_rd - rd_base < zp) ? 1'b0 : stat[1];
      n_rd <= n_rd + 1;
    end
    if (acia_cs && acia_we && acia_rs) begin
      dlog.push_back(acia_din);
      if (!last_txe) bad_tx <= bad_tx + 1;
    end
    if (acia_cs && acia_we && !acia_rs) n_ctl <= n_ctl + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_data(input int n, input int budget);
    int k = 0;
    while (dlog.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("data_wait", dlog.size() >= n, 1);
  endtask

  task automatic reset_quiet();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int base, rb, cb, bt;
    logic found;
    // reset values and init sequence
    #1;
    chk("rst_cs", acia_cs, 0);
    chk("rst_we", acia_we, 0);
    chk("rst_din", acia_din, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_init", init_done, 0);
    chk("rst_rdy", {req0_rdy, req1_rdy}, 2'b00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("c1_ctl", {acia_cs, acia_we, acia_rs}, 3'b110);
    chk("c1_din", acia_din, 8'h03);
    @(negedge clk);
    chk("c2_ctl", {acia_cs, acia_we, acia_rs}, 3'b110);
    chk("c2_din", acia_din, 8'h00);
    @(negedge clk);
    chk("c3_init", init_done, 1);
    chk("c3_rdy", {req0_rdy, req1_rdy}, 2'b11);
    chk("c3_idle", {acia_cs, busy}, 2'b00);
    // single byte
    req0_dat = 8'h41;
    req0_vld = 1'b1;
    @(negedge clk);
    req0_vld = 1'b0;
    chk("s_idle", {acia_cs, busy}, 2'b01);
    @(negedge clk);
    chk("s_poll", {acia_cs, acia_we, acia_rs}, 3'b100);
    @(negedge clk);
    chk("s_check", {acia_cs, acia_din}, 9'h000);
    @(negedge clk);
    chk("s_send", {acia_cs, acia_we, acia_rs}, 3'b111);
    chk("s_send_din", acia_din, 8'h41);
    @(negedge clk);
    chk("s_busy_low", busy, 0);
    // round robin with both FIFOs loaded
    reset_quiet();
    base = dlog.size();
    req0_dat = 8'hA0;
    req1_dat = 8'hB0;
    {req0_vld, req1_vld} = 2'b11;
    @(negedge clk);
    req0_dat = 8'hA1;
    req1_dat = 8'hB1;
    @(negedge clk);
    {req0_vld, req1_vld} = 2'b00;
    wait_data(base + 4, 60);
    chk("rr0", dlog[base], 8'hA0);
    chk("rr1", dlog[base+1], 8'hB0);
    chk("rr2", dlog[base+2], 8'hA1);
    chk("rr3", dlog[base+3], 8'hB1);
    // five busy polls then ready
    @(negedge clk);
    base = dlog.size();
    rd_base = n_rd;
    bt = bad_tx;
    zp = 5;
    req0_dat = 8'h5A;
    req0_vld = 1'b1;
    @(negedge clk);
    req0_vld = 1'b0;
    wait_data(base + 1, 60);
    repeat (3) @(negedge clk);
    chk("poll_reads", n_rd - rd_base, 6);
    chk("poll_writes", dlog.size() - base, 1);
    chk("poll_byte", dlog[base], 8'h5A);
    chk("poll_no_early", bad_tx - bt, 0);
    // fill req1 while TXE is low
    zp = 0;
    stat = 8'h00;
    base = dlog.size();
    req1_vld = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req1_dat = 8'h10 + 8'(i);
      @(negedge clk);
    end
    chk("full_rdy", req1_rdy, 0);
    req1_dat = 8'h20;
    repeat (3) @(negedge clk);
    chk("full_hold", req1_rdy, 0);
    stat = 8'h02;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = acia_cs & acia_we & acia_rs;
    end
    chk("full_send_seen", found, 1);
    chk("full_no_bypass", req1_rdy, 0);
    @(negedge clk);
    chk("full_rdy_back", req1_rdy, 1);
    @(negedge clk);
    req1_vld = 1'b0;
    wait_data(base + 17, 200);
    for (int i = 0; i < 17; i++) chk($sformatf("order%0d", i), dlog[base+i], 8'h10 + 8'(i));
    // reset during CHECK with bytes queued
    stat = 8'h00;
    req0_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_dat = 8'h60 + 8'(i);
      @(negedge clk);
    end
    req0_vld = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = acia_cs & ~acia_we;
    end
    chk("mid_poll_seen", found, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_bus", {acia_cs, acia_we, acia_rs, acia_din}, 11'h000);
    chk("mid_flags", {init_done, busy, req0_rdy, req1_rdy}, 4'h0);
    base = dlog.size();
    cb = n_ctl;
    rb = n_rd;
    stat = 8'h02;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("mid_no_data", dlog.size() - base, 0);
    chk("mid_ctl_writes", n_ctl - cb, 2);
    chk("mid_no_reads", n_rd - rb, 0);
    chk("mid_idle", {init_done, busy}, 2'b10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/acia_tx_sched.md
ACIA_TX_SCHED -- requirements
Module: acia_tx_sched

Interface
REQ-001 Parameter DEPTH, default 16, per-requester byte FIFO depth; power of two, >= 2.
REQ-002 Parameter CFG_WORD, default 8'h00, ACIA control word written after master reset.
REQ-003 clk  input  1  system clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_dat  input  8  requester 0 byte.
REQ-006 req0_vld  input  1  requester 0 byte valid.
REQ-007 req0_rdy  output  1  requester 0 may push; transfer when vld&rdy.
REQ-008 req1_dat  input  8  requester 1 byte.
REQ-009 req1_vld  input  1  requester 1 byte valid.
REQ-010 req1_rdy  output  1  requester 1 may push.
REQ-011 acia_cs  output  1  ACIA chip select.
REQ-012 acia_we  output  1  ACIA write enable.
REQ-013 acia_rs  output  1  ACIA register select (0 control/status, 1 data).
REQ-014 acia_din  output  8  ACIA write data.
REQ-015 acia_dout  input  8  ACIA read data, valid the cycle after a read strobe.
REQ-016 init_done  output  1  high once ACIA configuration is complete.
REQ-017 busy  output  1  high when either FIFO is non-empty or the FSM is not in IDLE.

Function
REQ-018 FSM states: INIT_MR, INIT_CFG, IDLE, POLL, CHECK, SEND.
REQ-019 INIT_MR: one cycle, cs=1 we=1 rs=0 din=8'h03 (master reset); next INIT_CFG.
REQ-020 INIT_CFG: one cycle, cs=1 we=1 rs=0 din=CFG_WORD; next IDLE; init_done set on entering IDLE and held until reset.
REQ-021 IDLE: if any FIFO is non-empty, latch grant per REQ-025 and go to POLL; else remain; bus outputs cs=we=rs=0.
REQ-022 POLL: one cycle, cs=1 we=0 rs=0 (status read); next CHECK.
REQ-023 CHECK: cs=0; sample acia_dout[1] (TX empty); if 1 go to SEND, else go to POLL (continuous polling, one read per two cycles).
REQ-024 SEND: one cycle, cs=1 we=1 rs=1 din=head byte of granted FIFO; pop that FIFO this cycle; toggle round-robin pointer; next IDLE.
REQ-025 Arbitration: round-robin; pointer reset value 0; if only one FIFO non-empty grant it; if both, grant the pointer's requester; after SEND pointer = other requester.
REQ-026 Grant is latched in IDLE and fixed through POLL/CHECK/SEND; pushes during that window do not alter it.
REQ-027 FIFO push when reqN_vld & reqN_rdy; reqN_rdy = init_done & ~fullN.
REQ-028 Full FIFO: rdy=0; a pop in SEND re-asserts rdy the following cycle (no same-cycle bypass).
REQ-029 Simultaneous push and pop on the same FIFO: both take effect; occupancy unchanged.
REQ-030 FIFO pointers are log2(DEPTH)+1 bits with natural wrap; full when MSBs differ and remaining bits equal.
REQ-031 Byte order per requester preserved; each accepted byte is written to the ACIA exactly once.
REQ-032 acia_din = 8'h00 whenever acia_cs=0.

Reset
REQ-033 On rst_n low: state=INIT_MR, FIFOs empty, pointer=0, grant=0, cs=we=rs=0, din=8'h00, init_done=0, busy=0, rdy=0.
REQ-034 Reset mid-transfer discards all queued bytes; INIT_MR reissued on the first clock after release.

Structure
REQ-035 Shared package acia_pkg holds: FSM state enum, ACIA_MRST=8'h03, STAT_TXE_BIT=1, STAT_RXF_BIT=0.
REQ-036 One sub-module acia_fifo (synchronous byte FIFO, parameter DEPTH), instantiated twice.

Verification
REQ-037 Reset release -> cycle 1 write ctrl 8'h03, cycle 2 write ctrl 8'h00, init_done=1 cycle 3, rdy0=rdy1=1.
REQ-038 Push 8'h41 on req0, status returns 8'h02 -> POLL, CHECK, SEND data write 8'h41 with rs=1, busy falls after.
REQ-039 Both FIFOs loaded {A0,A1} and {B0,B1}, TXE always 1 -> ACIA data writes A0,B0,A1,B1.
REQ-040 Status returns 8'h00 for 5 polls then 8'h02 -> exactly 6 status reads, then one data write; no write while TXE=0.
REQ-041 Push 16 bytes to req1 with TXE=0 -> rdy1=0 after 16th; TXE=1 -> rdy1=1 one cycle after first SEND; all 17 bytes out in order.
REQ-042 rst_n low during CHECK with 3 bytes queued -> all outputs at reset values immediately; after release only init writes, no data writes.
